// File: rtl/cv32e40x_div_iter.sv
// Iterative shift-subtract divider for DIV/DIVU/REM/REMU.
// Uses the ALU CLZ unit to size each operation and the ALU shifter to align the divisor.
module cv32e40x_div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        kill_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [1:0]  op_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic        div_clz_en_o,
  output logic [31:0] div_clz_data_o,
  input  logic [5:0]  div_clz_result_i,
  output logic        div_shift_en_o,
  output logic [5:0]  div_shift_amt_o,
  output logic [31:0] op_b_abs_o,
  input  logic [31:0] div_op_b_shifted_i
);

  localparam int unsigned W     = 32;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {IDLE, INIT, DIVIDE, FINISH} state_e;

  state_e           state_q;
  logic             is_rem_q;
  logic             a_neg_q;
  logic             b_neg_q;
  logic [W-1:0]     b_abs_q;
  logic [W-1:0]     rem_q;
  logic [W-1:0]     quot_q;
  logic [W-1:0]     result_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic             valid_q;
  logic             clz_en_q;
  logic             shift_en_q;

  logic             op_signed;
  logic             a_neg;
  logic             b_neg;
  logic [W-1:0]     a_abs;
  logic [W-1:0]     b_abs;

  logic             sub_ok;
  logic [W-1:0]     rem_step;
  logic [W-1:0]     quot_step;

  logic             div_zero;
  logic             q_neg;
  logic [W-1:0]     q_src;
  logic [W-1:0]     r_src;
  logic [W-1:0]     q_final;
  logic [W-1:0]     r_final;
  logic [W-1:0]     res_final;

  // Operand magnitudes; negating 0x80000000 wraps to itself, which is 2^31 unsigned
  always_comb begin
    op_signed = ~op_i[0];
    a_neg     = op_signed & op_a_i[W-1];
    b_neg     = op_signed & op_b_i[W-1];
    a_abs     = a_neg ? (W'(0) - op_a_i) : op_a_i;
    b_abs     = b_neg ? (W'(0) - op_b_i) : op_b_i;
  end

  // One restoring step against the divisor shifted left by cnt
  always_comb begin
    sub_ok          = (rem_q >= div_op_b_shifted_i);
    rem_step        = sub_ok ? (rem_q - div_op_b_shifted_i) : rem_q;
    quot_step       = quot_q;
    quot_step[cnt_q] = quot_q[cnt_q] | sub_ok;
  end

  // Final result selection with sign fix-up; a zero divisor keeps an all-ones quotient
  always_comb begin
    div_zero = (div_clz_result_i == 6'd32);
    if (state_q == INIT) begin
      q_src = '1;
      r_src = rem_q;
      q_neg = 1'b0;
    end else begin
      q_src = quot_step;
      r_src = rem_step;
      q_neg = a_neg_q ^ b_neg_q;
    end
    q_final   = q_neg   ? (W'(0) - q_src) : q_src;
    r_final   = a_neg_q ? (W'(0) - r_src) : r_src;
    res_final = is_rem_q ? r_final : q_final;
  end

  // Control FSM with registered handshake, ALU-request and result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      is_rem_q   <= 1'b0;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      b_abs_q    <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      clz_en_q   <= 1'b0;
      shift_en_q <= 1'b0;
    end else if (kill_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      clz_en_q   <= 1'b0;
      shift_en_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i && ready_q) begin
            is_rem_q <= op_i[1];
            a_neg_q  <= a_neg;
            b_neg_q  <= b_neg;
            b_abs_q  <= b_abs;
            rem_q    <= a_abs;
            quot_q   <= '0;
            ready_q  <= 1'b0;
            clz_en_q <= 1'b1;
            state_q  <= INIT;
          end
        end
        INIT: begin
          clz_en_q <= 1'b0;
          if (div_zero) begin
            result_q <= res_final;
            valid_q  <= 1'b1;
            state_q  <= FINISH;
          end else begin
            cnt_q      <= div_clz_result_i[CNT_W-1:0];
            quot_q     <= '0;
            shift_en_q <= 1'b1;
            state_q    <= DIVIDE;
          end
        end
        DIVIDE: begin
          rem_q  <= rem_step;
          quot_q <= quot_step;
          if (cnt_q == '0) begin
            shift_en_q <= 1'b0;
            result_q   <= res_final;
            valid_q    <= 1'b1;
            state_q    <= FINISH;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        FINISH: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o         = ready_q;
  assign valid_o         = valid_q;
  assign result_o        = result_q;
  assign div_clz_en_o    = clz_en_q;
  assign div_clz_data_o  = b_abs_q;
  assign div_shift_en_o  = shift_en_q;
  assign div_shift_amt_o = {1'b0, cnt_q};
  assign op_b_abs_o      = b_abs_q;

endmodule

// File: tb/tb_cv32e40x_div_iter.sv
// Scoreboard bench for cv32e40x_div_iter: driver pushes expected results, monitor checks outputs.
module tb_cv32e40x_div_iter;

  logic        clk;
  logic        rst;
  logic        kill_i;
  logic        valid_i;
  logic        ready_o;
  logic [1:0]  op_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        div_clz_en_o;
  logic [31:0] div_clz_data_o;
  logic [5:0]  div_clz_result_i;
  logic        div_shift_en_o;
  logic [5:0]  div_shift_amt_o;
  logic [31:0] op_b_abs_o;
  logic [31:0] div_op_b_shifted_i;

  cv32e40x_div_iter dut (
    .clk                (clk),
    .rst                (rst),
    .kill_i             (kill_i),
    .valid_i            (valid_i),
    .ready_o            (ready_o),
    .op_i               (op_i),
    .op_a_i             (op_a_i),
    .op_b_i             (op_b_i),
    .valid_o            (valid_o),
    .ready_i            (ready_i),
    .result_o           (result_o),
    .div_clz_en_o       (div_clz_en_o),
    .div_clz_data_o     (div_clz_data_o),
    .div_clz_result_i   (div_clz_result_i),
    .div_shift_en_o     (div_shift_en_o),
    .div_shift_amt_o    (div_shift_amt_o),
    .op_b_abs_o         (op_b_abs_o),
    .div_op_b_shifted_i (div_op_b_shifted_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ALU-side helpers: count leading zeros and the shifter
  function automatic logic [5:0] clz32(input logic [31:0] v);
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) return 6'(31 - i);
    end
    return 6'd32;
  endfunction

  always_comb begin
    div_clz_result_i   = clz32(div_clz_data_o);
    div_op_b_shifted_i = op_b_abs_o << div_shift_amt_o;
  end

  // Reference: architectural RV32M results using wide integer arithmetic
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    ua = longint'(a);
    ub = longint'(b);
    return op[1] ? 32'(ua % ub) : 32'(ua / ub);
  endfunction

  function automatic logic [31:0] mag_b(input logic [1:0] op, input logic [31:0] b);
    return (!op[0] && b[31]) ? (32'd0 - b) : b;
  endfunction

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          shifts;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          nchk = 0;
  int          nfail = 0;
  int          bp_fixed = 0;
  logic [31:0] cur_b_abs = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    nchk++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Drive one request once the divider is ready; optionally push its expectation
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push);
    int   guard;
    exp_t x;
    logic [31:0] mb;
    guard = 0;
    @(negedge clk);
    while (!ready_o && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!ready_o) begin
      chk("issue_ready_timeout", 32'(ready_o), 32'd1);
      return;
    end
    op_i    = op;
    op_a_i  = a;
    op_b_i  = b;
    valid_i = 1'b1;
    mb        = mag_b(op, b);
    cur_b_abs = mb;
    if (push) begin
      x.res    = ref_result(op, a, b);
      x.lat    = (mb == 32'd0) ? 2 : 3 + int'(clz32(mb));
      x.shifts = (mb == 32'd0) ? 0 : 1 + int'(clz32(mb));
      x.acc    = cyc;
      sb.push_back(x);
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb.size() != 0 || !ready_o) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    chk("drain_queue_empty", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: compares outputs, applies backpressure and checks the return to idle
  bit          seen = 1'b0;
  bit          expect_idle = 1'b0;
  int          hold = 0;
  int          shift_cnt = 0;
  logic [31:0] held = 32'd0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        seen        = 1'b0;
        expect_idle = 1'b0;
        shift_cnt   = 0;
        ready_i     = 1'b1;
      end else begin
        if (expect_idle) begin
          chk("idle_ready_o", 32'(ready_o), 32'd1);
          chk("idle_valid_o", 32'(valid_o), 32'd0);
          expect_idle = 1'b0;
        end
        if (div_clz_en_o) begin
          chk("clz_data", div_clz_data_o, cur_b_abs);
          chk("clz_shift_excl", 32'(div_shift_en_o), 32'd0);
        end
        if (div_shift_en_o) shift_cnt++;
        if (ready_o) shift_cnt = 0;
        if (valid_o) begin
          if (!seen) begin
            if (sb.size() == 0) begin
              chk("unexpected_valid", 32'(valid_o), 32'd0);
            end else begin
              e = sb.pop_front();
              chk("result", result_o, e.res);
              chk("latency", 32'(cyc - e.acc), 32'(e.lat));
              chk("shift_cycles", 32'(shift_cnt), 32'(e.shifts));
              chk("finish_ready_o", 32'(ready_o), 32'd0);
              held = result_o;
              seen = 1'b1;
              hold = (bp_fixed >= 0) ? bp_fixed : int'($urandom_range(0, 3));
            end
          end else begin
            chk("hold_result", result_o, held);
            chk("hold_ready_o", 32'(ready_o), 32'd0);
          end
          if (seen && hold > 0) begin
            ready_i = 1'b0;
            hold--;
          end else begin
            ready_i     = 1'b1;
            seen        = 1'b0;
            expect_idle = 1'b1;
          end
        end else begin
          ready_i = 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [1:0]  d_op [11];
  logic [31:0] d_a  [11];
  logic [31:0] d_b  [11];

  initial begin
    rst     = 1'b1;
    kill_i  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    op_i    = 2'b00;
    op_a_i  = 32'd0;
    op_b_i  = 32'd0;

    d_op = '{2'b01, 2'b11, 2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10};
    d_a  = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000,
             32'h8000_0000, 32'd5, 32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
    d_b  = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             32'd0, 32'd0, 32'd0, 32'd0};

    repeat (3) @(negedge clk);
    chk("rst_ready_o", 32'(ready_o), 32'd1);
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_result_o", result_o, 32'd0);
    chk("rst_clz_en", 32'(div_clz_en_o), 32'd0);
    chk("rst_shift_en", 32'(div_shift_en_o), 32'd0);
    chk("rst_shift_amt", 32'(div_shift_amt_o), 32'd0);
    rst = 1'b0;

    // Directed operand table
    for (int i = 0; i < 11; i++) issue(d_op[i], d_a[i], d_b[i], 1'b1);
    drain();

    // Backpressure: hold the result for five cycles
    bp_fixed = 5;
    issue(2'b01, 32'd1000, 32'd10, 1'b1);
    drain();
    bp_fixed = 0;

    // Kill at the tenth DIVIDE cycle, then a fresh operation
    issue(2'b01, 32'd1000, 32'd3, 1'b0);
    repeat (11) @(negedge clk);
    chk("kill_in_divide", 32'(div_shift_en_o), 32'd1);
    kill_i = 1'b1;
    @(posedge clk);
    #1;
    kill_i = 1'b0;
    @(negedge clk);
    chk("kill_ready_o", 32'(ready_o), 32'd1);
    chk("kill_shift_en", 32'(div_shift_en_o), 32'd0);
    chk("kill_valid_o", 32'(valid_o), 32'd0);
    issue(2'b01, 32'd9, 32'd3, 1'b1);
    drain();

    // Kill together with a request in IDLE must not accept it
    op_i    = 2'b01;
    op_a_i  = 32'd9;
    op_b_i  = 32'd3;
    valid_i = 1'b1;
    kill_i  = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    kill_i  = 1'b0;
    @(negedge clk);
    chk("kill_idle_ready_o", 32'(ready_o), 32'd1);
    chk("kill_idle_clz_en", 32'(div_clz_en_o), 32'd0);

    // Asynchronous reset in the middle of DIVIDE
    issue(2'b01, 32'd1000, 32'd3, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ready_o", 32'(ready_o), 32'd1);
    chk("arst_valid_o", 32'(valid_o), 32'd0);
    chk("arst_result_o", result_o, 32'd0);
    chk("arst_clz_en", 32'(div_clz_en_o), 32'd0);
    chk("arst_shift_en", 32'(div_shift_en_o), 32'd0);
    chk("arst_shift_amt", 32'(div_shift_amt_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Random operations with random backpressure
    bp_fixed = -1;
    for (int n = 0; n < 150; n++) begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0:       ra = 32'd0;
        1:       ra = 32'h8000_0000;
        2:       ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'h8000_0000;
        3:       rb = 32'($urandom_range(1, 15));
        4:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      issue(rop, ra, rb, 1'b1);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
